riscv_mc_controller: RTL and testbench

// - Multi-cycle RV32I control FSM: decodes the instruction register and sequences the datapath one state per cycle.
// - Drives the 3-bit ALU control code and the mux selects; consumes the ALU zero/sign flags to resolve branches.
// - Sits between the instruction register and the datapath, opposite the ALU on the ALU control/flag interface.

---
 rtl/riscv_mc_controller.sv | 213 +++++++++++++++++++++
 tb/tb_riscv_mc_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mc_controller.sv
// rtl/riscv_mc_controller.sv - multi-cycle RV32I control FSM (optional ILLEGAL_TRAP_EN trap state)
module riscv_mc_controller #(
    parameter int MEM_LATENCY = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       sign,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [2:0] alu_ctrl,
    output logic       illegal
);
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;
    localparam logic [2:0] ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010,
                           ALU_SUB = 3'b110, ALU_XOR = 3'b011, ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR, S_MEM_READ, S_MEM_WB,
        S_MEM_WRITE, S_BRANCH, S_JAL, S_JALR, S_JUMP_LINK, S_JUMP, S_LUI, S_ILLEGAL
    } state_t;

    state_t     state, state_n;
    logic [3:0] wait_cnt, wait_n;
    logic       last_wait;
    logic [2:0] alu_op;

    assign last_wait = (wait_cnt == 4'(MEM_LATENCY));

    // Only R-type honours funct7_5; the I-type bit 30 is immediate data.
    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            3'b000:  alu_op = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_op = ALU_AND;
            3'b110:  alu_op = ALU_OR;
            3'b100:  alu_op = ALU_XOR;
            3'b010:  alu_op = ALU_SLT;
            default: alu_op = ALU_ADD;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic f3_ok, br_ok;
    assign f3_ok = (funct3 == 3'b000) || (funct3 == 3'b111) || (funct3 == 3'b110) ||
                   (funct3 == 3'b100) || (funct3 == 3'b010);
    assign br_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b100) ||
                   (funct3 == 3'b101);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_n;
        end
    end

    always_comb begin
        state_n    = state;
        wait_n     = wait_cnt;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_ctrl   = ALU_ADD;
        illegal    = 1'b0;
        case (opcode)
            OP_I, OP_LOAD, OP_JALR: imm_src = 3'b000;
            OP_STORE:               imm_src = 3'b001;
            OP_BRANCH:              imm_src = 3'b010;
            OP_JAL:                 imm_src = 3'b011;
            OP_LUI:                 imm_src = 3'b100;
            default:                imm_src = 3'b000;
        endcase
        // Memory-access states stretch by MEM_LATENCY cycles; wait_cnt clears on exit.
        if (state == S_FETCH || state == S_MEM_READ || state == S_MEM_WRITE)
            wait_n = last_wait ? 4'd0 : 4'(wait_cnt + 4'd1);
        case (state)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_write   = last_wait;
                ir_write   = last_wait;
                if (last_wait) state_n = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_R:              state_n = S_EXEC_R;
                    OP_I:              state_n = S_EXEC_I;
                    OP_LOAD, OP_STORE: state_n = S_MEM_ADDR;
                    OP_BRANCH:         state_n = S_BRANCH;
                    OP_JAL:            state_n = S_JAL;
                    OP_JALR:           state_n = S_JALR;
                    OP_LUI:            state_n = S_LUI;
`ifdef ILLEGAL_TRAP_EN
                    default:           state_n = S_ILLEGAL;
`else
                    default:           state_n = S_FETCH;
`endif
                endcase
            end
            S_EXEC_R, S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = (state == S_EXEC_I) ? 2'b01 : 2'b00;
                alu_ctrl  = alu_op;
`ifdef ILLEGAL_TRAP_EN
                state_n   = f3_ok ? S_ALU_WB : S_ILLEGAL;
`else
                state_n   = S_ALU_WB;
`endif
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                state_n   = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_n   = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                adr_src = 1'b1;
                if (last_wait) state_n = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_n    = S_FETCH;
            end
            S_MEM_WRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (last_wait) state_n = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_ctrl  = ALU_SUB;
                case (funct3)
                    3'b000:  pc_write = zero;
                    3'b001:  pc_write = ~zero;
                    3'b100:  pc_write = sign;
                    3'b101:  pc_write = ~sign;
                    default: pc_write = 1'b0;
                endcase
`ifdef ILLEGAL_TRAP_EN
                state_n = br_ok ? S_FETCH : S_ILLEGAL;
`else
                state_n = S_FETCH;
`endif
            end
            S_JAL, S_JUMP_LINK: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                reg_write  = 1'b1;
                state_n    = S_JUMP;
            end
            S_JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_n   = S_JUMP_LINK;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                state_n  = S_FETCH;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                state_n   = S_ALU_WB;
            end
`ifdef ILLEGAL_TRAP_EN
            S_ILLEGAL: illegal = 1'b1;
`endif
            default: state_n = S_FETCH;
        endcase
        // Reset overrides everything so an aborted instruction issues no write.
        if (rst) begin
            pc_write   = 1'b0;
            adr_src    = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            result_src = 2'b00;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            imm_src    = 3'b000;
            alu_ctrl   = 3'b000;
            illegal    = 1'b0;
        end
    end
endmodule

// File: tb/tb_riscv_mc_controller.sv
// tb/tb_riscv_mc_controller.sv - scoreboard bench for riscv_mc_controller (latency 0 and 2 instances)
module tb_riscv_mc_controller;
    logic clk = 1'b0;
    logic rst0, rst1;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic funct7_5, zero, sign;

    logic pcw0, adr0, mw0, irw0, rw0, ill0, pcw1, adr1, mw1, irw1, rw1, ill1;
    logic [1:0] rs0, sa0, sb0, rs1, sa1, sb1;
    logic [2:0] imm0, alu0, imm1, alu1;

    typedef struct {
        string       name;
        logic [17:0] v;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [2:0] ADD = 3'b010, SUB = 3'b110, AND_ = 3'b000, OR_ = 3'b001,
                           XOR_ = 3'b011, SLT = 3'b111;
    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011,
                           BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, LUI = 7'b0110111;

    always #5 clk = ~clk;

    riscv_mc_controller #(.MEM_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst0), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .sign(sign), .pc_write(pcw0), .adr_src(adr0), .mem_write(mw0),
        .ir_write(irw0), .reg_write(rw0), .result_src(rs0), .alu_src_a(sa0), .alu_src_b(sb0),
        .imm_src(imm0), .alu_ctrl(alu0), .illegal(ill0));

    riscv_mc_controller #(.MEM_LATENCY(2)) dut1 (
        .clk(clk), .rst(rst1), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .sign(sign), .pc_write(pcw1), .adr_src(adr1), .mem_write(mw1),
        .ir_write(irw1), .reg_write(rw1), .result_src(rs1), .alu_src_a(sa1), .alu_src_b(sb1),
        .imm_src(imm1), .alu_ctrl(alu1), .illegal(ill1));

    // Vector layout: ill pcw adr memw irw regw rs[2] sa[2] sb[2] imm[3] alu[3]
    function automatic logic [17:0] cv(input logic ill, input logic pcw, input logic adr,
                                       input logic memw, input logic irw, input logic regw,
                                       input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [2:0] imm,
                                       input logic [2:0] alu);
        return {ill, pcw, adr, memw, irw, regw, rs, sa, sb, imm, alu};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic [17:0] a;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            a = {ill0, pcw0, adr0, mw0, irw0, rw0, rs0, sa0, sb0, imm0, alu0};
            n_cmp++;
            if (a !== e.v) begin
                n_bad++;
                $display("FAIL %s (lat0): got %b expected %b", e.name, a, e.v);
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            a = {ill1, pcw1, adr1, mw1, irw1, rw1, rs1, sa1, sb1, imm1, alu1};
            n_cmp++;
            if (a !== e.v) begin
                n_bad++;
                $display("FAIL %s (lat2): got %b expected %b", e.name, a, e.v);
            end
        end
    end

    task automatic cyc(input int d, input string nm, input logic [17:0] v);
        exp_t e;
        e.name = nm;
        e.v    = v;
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opcode   = op;
        funct3   = f3;
        funct7_5 = f7;
    endtask

    task automatic fetch(input int d, input string nm, input logic [2:0] imm, input logic last);
        cyc(d, {nm, "_fetch"}, cv(0, last, 0, 0, last, 0, 2'b10, 2'b00, 2'b10, imm, ADD));
    endtask

    task automatic decode(input int d, input string nm, input logic [2:0] imm);
        cyc(d, {nm, "_decode"}, cv(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, ADD));
    endtask

    task automatic run_alu(input string nm, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic [2:0] alu);
        set_instr(op, f3, f7);
        fetch(0, nm, 3'b000, 1);
        decode(0, nm, 3'b000);
        cyc(0, {nm, "_exec"}, cv(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, (op == R) ? 2'b00 : 2'b01,
                                 3'b000, alu));
        cyc(0, {nm, "_wb"}, cv(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, ADD));
    endtask

    task automatic run_br(input string nm, input logic [2:0] f3, input logic z, input logic s,
                          input logic taken);
        set_instr(BR, f3, 0);
        zero = z;
        sign = s;
        fetch(0, nm, 3'b010, 1);
        decode(0, nm, 3'b010);
        cyc(0, {nm, "_branch"}, cv(0, taken, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, SUB));
    endtask

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        zero = 1'b0;
        sign = 1'b0;
        set_instr(R, 3'b000, 0);
        @(posedge clk);
        #1;
        cyc(0, "reset", 18'd0);
        rst0 = 1'b0;

        run_alu("add", R, 3'b000, 0, ADD);
        run_alu("sub", R, 3'b000, 1, SUB);
        run_alu("slt", R, 3'b010, 0, SLT);
        run_alu("and", R, 3'b111, 0, AND_);
        run_alu("or", R, 3'b110, 0, OR_);
        run_alu("xor_i", I, 3'b100, 0, XOR_);
        run_alu("addi_f7", I, 3'b000, 1, ADD);

        run_br("beq_t", 3'b000, 1, 0, 1);
        run_br("beq_n", 3'b000, 0, 0, 0);
        run_br("bne_t", 3'b001, 0, 0, 1);
        run_br("blt_t", 3'b100, 0, 1, 1);
        run_br("bge_n", 3'b101, 0, 1, 0);

        set_instr(ST, 3'b010, 0);
        fetch(0, "sw", 3'b001, 1);
        decode(0, "sw", 3'b001);
        cyc(0, "sw_addr", cv(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, ADD));
        cyc(0, "sw_write", cv(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b001, ADD));

        set_instr(JAL, 3'b000, 0);
        fetch(0, "jal", 3'b011, 1);
        decode(0, "jal", 3'b011);
        cyc(0, "jal_link", cv(0, 0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b10, 3'b011, ADD));
        cyc(0, "jal_jump", cv(0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b011, ADD));

        set_instr(JALR, 3'b000, 0);
        fetch(0, "jalr", 3'b000, 1);
        decode(0, "jalr", 3'b000);
        cyc(0, "jalr_tgt", cv(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, ADD));
        cyc(0, "jalr_link", cv(0, 0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b10, 3'b000, ADD));
        cyc(0, "jalr_jump", cv(0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, ADD));

        set_instr(LUI, 3'b000, 0);
        fetch(0, "lui", 3'b100, 1);
        decode(0, "lui", 3'b100);
        cyc(0, "lui_exec", cv(0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 3'b100, ADD));
        cyc(0, "lui_wb", cv(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b100, ADD));

        set_instr(7'b0000000, 3'b000, 0);
        fetch(0, "nop0", 3'b000, 1);
        decode(0, "nop0", 3'b000);
`ifdef ILLEGAL_TRAP_EN
        for (int k = 0; k < 3; k++)
            cyc(0, "illegal_hold", cv(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, ADD));
        rst0 = 1'b1;
        cyc(0, "illegal_rst", 18'd0);
        rst0 = 1'b0;
`endif
        fetch(0, "after_nop0", 3'b000, 1);

        // Latency-2 instance: lw timing and reset inside a stretched store.
        rst0 = 1'b1;
        set_instr(LD, 3'b010, 0);
        cyc(1, "lat2_reset", 18'd0);
        rst1 = 1'b0;
        fetch(1, "lw1", 3'b000, 0);
        fetch(1, "lw2", 3'b000, 0);
        fetch(1, "lw3", 3'b000, 1);
        decode(1, "lw", 3'b000);
        cyc(1, "lw_addr", cv(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, ADD));
        for (int k = 0; k < 3; k++)
            cyc(1, "lw_read", cv(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, ADD));
        cyc(1, "lw_wb", cv(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, ADD));

        set_instr(ST, 3'b010, 0);
        fetch(1, "sw1", 3'b001, 0);
        fetch(1, "sw2", 3'b001, 0);
        fetch(1, "sw3", 3'b001, 1);
        decode(1, "sw", 3'b001);
        cyc(1, "sw_addr", cv(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, ADD));
        cyc(1, "sw_write", cv(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b001, ADD));
        rst1 = 1'b1;
        cyc(1, "sw_rst", 18'd0);
        rst1 = 1'b0;
        fetch(1, "post_rst1", 3'b001, 0);
        fetch(1, "post_rst2", 3'b001, 0);
        fetch(1, "post_rst3", 3'b001, 1);

        @(negedge clk);
        #1;
        n_cmp++;
        if (q0.size() + q1.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q0.size() + q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
